// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel plus the decoder-facing
// opcode, stall and redirect signals. master = fetch unit, slave = memory/decoder side.
interface fetch_unit_if #(
    parameter int unsigned PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [7:0]      imem_data;
    logic            stall_in;
    logic            redirect_en;
    logic [PC_W-1:0] redirect_pc;
    logic [7:0]      opcode;
    logic            opcode_valid;
    logic [PC_W-1:0] opcode_pc;

    modport master (
        output imem_req, imem_addr, opcode, opcode_valid, opcode_pc,
        input  imem_ack, imem_data, stall_in, redirect_en, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, opcode, opcode_valid, opcode_pc,
        output imem_ack, imem_data, stall_in, redirect_en, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack byte fetches, prefetch FIFO feeding the decoder.
// Optional macro FETCH_PERF_EN adds saturating stall/drop performance counters.
module fetch_unit #(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         async_rst_n,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]  perf_stall_cnt,
    output logic [15:0]  perf_drop_cnt
`endif
);
    localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    typedef enum logic {ST_RUN, ST_DROP} state_t;

    state_t           r_state, w_state_next;
    logic [PC_W-1:0]  r_pc, r_saved_pc;
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PC_W-1:0]  r_mem_pc   [DEPTH];
    logic [7:0]       r_mem_data [DEPTH];

    logic w_req, w_ack_hit, w_valid, w_push, w_pop, w_redirect_drop;

    assign w_valid         = (r_count != '0);
    assign w_ack_hit       = w_req && bus.imem_ack;
    assign w_push          = w_ack_hit && (r_state == ST_RUN) && !bus.redirect_en;
    assign w_pop           = w_valid && !bus.stall_in && !bus.redirect_en;
    // A redirect while a request is still outstanding must wait out that request.
    assign w_redirect_drop = bus.redirect_en && w_req && !bus.imem_ack;

    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        if (bus.redirect_en) begin
            w_state_next = w_redirect_drop ? ST_DROP : ST_RUN;
        end else if ((r_state == ST_DROP) && w_ack_hit) begin
            w_state_next = ST_RUN;
        end
    end

    always_comb begin
        w_req = 1'b0;
        if (async_rst_n) begin
            case (r_state)
                ST_RUN:  w_req = (r_count < FULL);
                ST_DROP: w_req = 1'b1;
                default: w_req = 1'b0;
            endcase
        end
    end

    // r_pc is the outstanding fetch address; while dropping, the redirect target waits in r_saved_pc.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_pc       <= RESET_PC;
            r_saved_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (bus.redirect_en) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            if (w_redirect_drop) begin
                r_saved_pc <= bus.redirect_pc;
            end else begin
                r_pc <= bus.redirect_pc;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_pc     <= r_pc + PC_W'(1);
            end else if ((r_state == ST_DROP) && w_ack_hit) begin
                r_pc <= r_saved_pc;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // NOTE: the storage array is not reset; only entries below r_count are ever presented.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_pc;
            r_mem_data[r_wr_ptr] <= bus.imem_data;
        end
    end

    assign bus.imem_req     = w_req;
    assign bus.imem_addr    = r_pc;
    assign bus.opcode_valid = w_valid;
    assign bus.opcode       = w_valid ? r_mem_data[r_rd_ptr] : 8'h00;
    assign bus.opcode_pc    = w_valid ? r_mem_pc[r_rd_ptr] : '0;

`ifdef FETCH_PERF_EN
    logic [15:0]      r_perf_stall, r_perf_drop;
    logic [CNT_W-1:0] w_drop_inc;
    logic [16:0]      w_drop_sum;

    // Discarded bytes: flushed entries plus any ack whose data is thrown away.
    always_comb begin
        w_drop_inc = '0;
        if (bus.redirect_en) begin
            w_drop_inc = r_count + CNT_W'(w_ack_hit);
        end else if ((r_state == ST_DROP) && w_ack_hit) begin
            w_drop_inc = CNT_W'(1);
        end
    end

    assign w_drop_sum = {1'b0, r_perf_drop} + 17'(w_drop_inc);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_perf_stall <= '0;
            r_perf_drop  <= '0;
        end else begin
            if (w_valid && bus.stall_in && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
            r_perf_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_drop_cnt  = r_perf_drop;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized stall/redirect/latency
// traffic, checked every cycle against a queue-based behavioural model.
module tb_fetch_unit;
    localparam int         PC_W     = 8;
    localparam int         DEPTH    = 4;
    localparam logic [7:0] RESET_PC = 8'h00;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic async_rst_n = 1'b0;

    fetch_unit_if #(.PC_W(PC_W)) bus();

`ifdef FETCH_PERF_EN
    logic [15:0] perf_stall_cnt, perf_drop_cnt;
`endif

    fetch_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .bus         (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: bytes the decoder can still see, the outstanding fetch address, and whether
    // the outstanding fetch is a stale one that must be thrown away.
    ent_t       m_q[$];
    logic [7:0] m_pc, m_saved;
    bit         m_drop;
    int         m_stall_cnt, m_drop_cnt;

    int lat, wait_cnt, n_acks;
    bit lat_rand;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_req_f();
        return async_rst_n && (m_drop || (m_q.size() < DEPTH));
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_pc        = RESET_PC;
        m_saved     = RESET_PC;
        m_drop      = 1'b0;
        m_stall_cnt = 0;
        m_drop_cnt  = 0;
        wait_cnt    = 0;
    endfunction

    function automatic void model_step(input bit req, input bit ack, input logic [7:0] data,
                                       input bit stall, input bit redir, input logic [7:0] rpc);
        bit hit   = req && ack;
        bit valid = (m_q.size() != 0);
        if (valid && stall) m_stall_cnt = sat(m_stall_cnt + 1);
        if (redir) begin
            m_drop_cnt = sat(m_drop_cnt + m_q.size() + (hit ? 1 : 0));
            m_q.delete();
            if (req && !ack) begin
                m_drop  = 1'b1;
                m_saved = rpc;
            end else begin
                m_drop = 1'b0;
                m_pc   = rpc;
            end
        end else begin
            if (valid && !stall) void'(m_q.pop_front());
            if (hit) begin
                if (m_drop) begin
                    m_drop_cnt = sat(m_drop_cnt + 1);
                    m_drop     = 1'b0;
                    m_pc       = m_saved;
                end else begin
                    m_q.push_back('{m_pc, data});
                    m_pc = m_pc + 8'd1;
                end
            end
        end
    endfunction

    // One clock: memory answers after `lat` waiting cycles with data = addr ^ 8'hA5.
    task automatic cycle(input bit stall, input bit redir, input logic [7:0] rpc);
        bit req, ack;
        logic [7:0] data;
        req  = m_req_f();
        ack  = req && (wait_cnt >= lat);
        data = m_pc ^ 8'hA5;
        bus.imem_ack    = ack;
        bus.imem_data   = ack ? data : 8'($urandom);
        bus.stall_in    = stall;
        bus.redirect_en = redir;
        bus.redirect_pc = rpc;
        @(posedge clk);
        #1;
        model_step(req, ack, data, stall, redir, rpc);
        if (ack) begin
            n_acks++;
            wait_cnt = 0;
            if (lat_rand) lat = $urandom_range(0, 3);
        end else if (req) begin
            wait_cnt++;
        end
    endtask

    task automatic do_reset();
        cmp_en          = 1'b0;
        async_rst_n     = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_data   = 8'h00;
        bus.stall_in    = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 8'h00;
        #1;
        check("rst_req",    32'(bus.imem_req),     32'(0));
        check("rst_valid",  32'(bus.opcode_valid), 32'(0));
        check("rst_opcode", 32'(bus.opcode),       32'(0));
        check("rst_pc",     32'(bus.opcode_pc),    32'(0));
`ifdef FETCH_PERF_EN
        check("rst_perf_stall", 32'(perf_stall_cnt), 32'(0));
        check("rst_perf_drop",  32'(perf_drop_cnt),  32'(0));
`endif
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        async_rst_n = 1'b1;
        #1;
        cmp_en = 1'b1;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("req", 32'(bus.imem_req), 32'(m_req_f()));
            if (m_req_f()) check("addr", 32'(bus.imem_addr), 32'(m_pc));
            check("valid", 32'(bus.opcode_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("opcode",    32'(bus.opcode),    32'(m_q[0].data));
                check("opcode_pc", 32'(bus.opcode_pc), 32'(m_q[0].pc));
            end
`ifdef FETCH_PERF_EN
            check("perf_stall", 32'(perf_stall_cnt), 32'(m_stall_cnt));
            check("perf_drop",  32'(perf_drop_cnt),  32'(m_drop_cnt));
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_ops [4];
        int n;
        exp_ops = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
        lat_rand = 1'b0;
        lat      = 0;
        n_acks   = 0;

        // Back-to-back acks, no stall: one opcode per cycle, 1-cycle ack->valid latency.
        do_reset();
        check("s1_idle_valid", 32'(bus.opcode_valid), 32'(0));
        check("s1_idle_req",   32'(bus.imem_req),     32'(1));
        check("s1_idle_addr",  32'(bus.imem_addr),    32'(RESET_PC));
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 8'h00);
            check("s1_valid",  32'(bus.opcode_valid), 32'(1));
            check("s1_opcode", 32'(bus.opcode),       32'(exp_ops[i]));
            check("s1_pc",     32'(bus.opcode_pc),    32'(i));
        end

        // Stall from reset: FIFO fills with exactly DEPTH bytes, then fetching idles.
        do_reset();
        n_acks = 0;
        repeat (8) cycle(1'b1, 1'b0, 8'h00);
        check("s2_acks",   32'(n_acks),        32'(4));
        check("s2_req",    32'(bus.imem_req),  32'(0));
        check("s2_opcode", 32'(bus.opcode),    32'(8'hA5));
        check("s2_pc",     32'(bus.opcode_pc), 32'(0));
        check("s2_addr",   32'(bus.imem_addr), 32'(4));
        for (int i = 0; i < 4; i++) begin
            check("s2_pop_pc", 32'(bus.opcode_pc), 32'(i));
            cycle(1'b0, 1'b0, 8'h00);
        end
        check("s2_resume_pc",     32'(bus.opcode_pc), 32'(4));
        check("s2_resume_opcode", 32'(bus.opcode),    32'(8'hA1));

        // Latency 3; redirect on the 2nd waiting cycle of the fetch to address 2.
        do_reset();
        lat = 3;
        n = 0;
        while (!(m_pc == 8'd2 && wait_cnt == 1) && n < 40) begin
            cycle(1'b0, 1'b0, 8'h00);
            n++;
        end
        check("s3_reached", 32'(n < 40), 32'(1));
        cycle(1'b0, 1'b1, 8'h40);
        check("s3_drop_req",  32'(bus.imem_req),  32'(1));
        check("s3_drop_addr", 32'(bus.imem_addr), 32'(2));
        cycle(1'b0, 1'b0, 8'h00);
        check("s3_hold_addr", 32'(bus.imem_addr), 32'(2));
        cycle(1'b0, 1'b0, 8'h00);
        check("s3_new_addr",  32'(bus.imem_addr),    32'(8'h40));
        check("s3_no_valid",  32'(bus.opcode_valid), 32'(0));
        n = 0;
        while (!bus.opcode_valid && n < 10) begin
            cycle(1'b0, 1'b0, 8'h00);
            n++;
        end
        check("s3_valid",  32'(bus.opcode_valid), 32'(1));
        check("s3_pc",     32'(bus.opcode_pc),    32'(8'h40));
        check("s3_opcode", 32'(bus.opcode),       32'(8'hE5));

        // Redirect in the same cycle as the ack for address 5: that byte never appears.
        do_reset();
        lat = 0;
        n = 0;
        while (m_pc != 8'd5 && n < 20) begin
            cycle(1'b0, 1'b0, 8'h00);
            n++;
        end
        check("s4_reached", 32'(n < 20), 32'(1));
        cycle(1'b0, 1'b1, 8'h80);
        check("s4_empty", 32'(bus.opcode_valid), 32'(0));
        check("s4_addr",  32'(bus.imem_addr),    32'(8'h80));
        cycle(1'b0, 1'b0, 8'h00);
        check("s4_pc",     32'(bus.opcode_pc), 32'(8'h80));
        check("s4_opcode", 32'(bus.opcode),    32'(8'h25));

        // PC wrap from 0xFF to 0x00.
        cycle(1'b0, 1'b1, 8'hFE);
        check("s5_addr_fe", 32'(bus.imem_addr), 32'(8'hFE));
        cycle(1'b0, 1'b0, 8'h00);
        check("s5_pc_fe", 32'(bus.opcode_pc), 32'(8'hFE));
        cycle(1'b0, 1'b0, 8'h00);
        check("s5_pc_ff",   32'(bus.opcode_pc), 32'(8'hFF));
        check("s5_addr_00", 32'(bus.imem_addr), 32'(8'h00));
        cycle(1'b0, 1'b0, 8'h00);
        check("s5_pc_00",     32'(bus.opcode_pc), 32'(8'h00));
        check("s5_opcode_00", 32'(bus.opcode),    32'(8'hA5));

        // Asynchronous reset in the middle of a DROP.
        do_reset();
        lat = 0;
        repeat (3) cycle(1'b0, 1'b0, 8'h00);
        lat = 3;
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h33);
        check("s6_drop_addr", 32'(bus.imem_addr), 32'(3));
        #2;
        do_reset();
        check("s6_restart_addr", 32'(bus.imem_addr), 32'(RESET_PC));
        check("s6_restart_req",  32'(bus.imem_req),  32'(1));
        lat = 0;
        cycle(1'b0, 1'b0, 8'h00);
        check("s6_first_pc",     32'(bus.opcode_pc), 32'(RESET_PC));
        check("s6_first_opcode", 32'(bus.opcode),    32'(RESET_PC ^ 8'hA5));

        // Randomized traffic: latency 0..3, stalls, redirects (including during DROP).
        do_reset();
        lat_rand = 1'b1;
        lat      = $urandom_range(0, 3);
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0, 8'($urandom));
        end
        bus.redirect_en = 1'b0;
        bus.imem_ack    = 1'b0;
        @(negedge clk);
        #1;
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
